// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a DEPTH-entry character FIFO.
// Frames are start / DATA_BITS data (LSB first) / optional parity / 1-2 stop.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   baud_div_i           bit period minus one, in clk cycles
//   parity_i             00/11 none, 01 even, 10 odd (latched per frame)
//   stop2_i              0 one stop bit, 1 two stop bits (latched per frame)
//   we_i, data_i         push a character (dropped when full)
//   stall_i              holds off the start of a new frame
//   full_o, empty_o      FIFO occupancy flags
//   level_o              FIFO entry count
//   busy_o               frame in progress
//   done_o               one-cycle pulse in the last cycle of the final stop bit
//   tx_o                 registered serial line, idle high
module uart_tx_fifo #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned DEPTH     = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [15:0]            baud_div_i,
  input  logic [1:0]             parity_i,
  input  logic                   stop2_i,
  input  logic                   we_i,
  input  logic [DATA_BITS-1:0]   data_i,
  input  logic                   stall_i,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   tx_o
);

  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned LW  = PW + 1;
  localparam int unsigned BCW = $clog2(DATA_BITS);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  logic [DATA_BITS-1:0] mem_q [DEPTH];

  state_e               state_q, state_d;
  logic [15:0]          baud_q, baud_d;
  logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_en_q, par_en_d;
  logic                 par_bit_q, par_bit_d;
  logic                 stop2_q, stop2_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic [PW-1:0]        wptr_q, wptr_d;
  logic [PW-1:0]        rptr_q, rptr_d;
  logic [LW-1:0]        count_q, count_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic bit_end;
  logic start_ok;
  logic push;
  logic pop;

  assign full_o  = (count_q == LW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign level_o = count_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign tx_o    = tx_q;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    stop2_d    = stop2_q;
    stop_cnt_d = stop_cnt_q;
    pop        = 1'b0;
    bit_end    = (baud_q == baud_div_i);
    start_ok   = !empty_o && !stall_i;
    push       = we_i && !full_o;

    case (state_q)
      IDLE: begin
        if (start_ok) pop = 1'b1;
      end
      START: begin
        if (bit_end) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_cnt_q == BCW'(DATA_BITS - 1)) begin
            state_d    = par_en_q ? PARITY : STOP;
            stop_cnt_d = 1'b0;
          end else begin
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + BCW'(1);
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d    = STOP;
          stop_cnt_d = 1'b0;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (stop2_q && !stop_cnt_q) stop_cnt_d = 1'b1;
          else if (start_ok)          pop        = 1'b1;
          else                        state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      state_d   = START;
      shift_d   = mem_q[rptr_q];
      par_en_d  = (parity_i == 2'b01) || (parity_i == 2'b10);
      par_bit_d = (^mem_q[rptr_q]) ^ (parity_i == 2'b10);
      stop2_d   = stop2_i;
    end

    // Pops only happen from IDLE or at a bit boundary, so both cases zero the counter.
    baud_d = ((state_q == IDLE) || bit_end) ? '0 : baud_q + 16'd1;

    wptr_d  = push ? wptr_q + PW'(1) : wptr_q;
    rptr_d  = pop  ? rptr_q + PW'(1) : rptr_q;
    count_d = count_q + LW'(push) - LW'(pop);

    case (state_d)
      IDLE:    tx_d = 1'b1;
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_bit_d;
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
    // Registered pulse: look ahead to the cycle that will be the final stop cycle.
    done_d = (state_d == STOP) && (baud_d == baud_div_i) && (stop_cnt_d == stop2_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
      stop_cnt_q <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      stop2_q    <= stop2_d;
      stop_cnt_q <= stop_cnt_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Storage is not reset; the pointers and count define what is valid.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: bench for uart_tx_fifo (DATA_BITS = 8, DEPTH = 4).
// Expected line waveforms are built from the frame format: per character a
// list of line levels expanded by the bit period, concatenated in FIFO order.
module tb_uart_tx_fifo;

  localparam int DB  = 8;
  localparam int DEP = 4;
  localparam int LW  = 3;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b1;
  logic [15:0]   baud_div_i = 16'd0;
  logic [1:0]    parity_i = 2'b00;
  logic          stop2_i = 1'b0;
  logic          we_i = 1'b0;
  logic [DB-1:0] data_i = '0;
  logic          stall_i = 1'b0;
  logic          full_o, empty_o, busy_o, done_o, tx_o;
  logic [LW-1:0] level_o;

  int check_cnt = 0;
  int pass_cnt  = 0;
  logic [7:0] mq[$];

  always #5 clk_i = ~clk_i;

  uart_tx_fifo #(.DATA_BITS(DB), .DEPTH(DEP)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .baud_div_i(baud_div_i), .parity_i(parity_i),
    .stop2_i(stop2_i), .we_i(we_i), .data_i(data_i), .stall_i(stall_i),
    .full_o(full_o), .empty_o(empty_o), .level_o(level_o), .busy_o(busy_o),
    .done_o(done_o), .tx_o(tx_o)
  );

  // Reference frame model: appends one character's line levels, busy and done.
  task automatic add_frame(inout logic [511:0] w, inout logic [511:0] dn,
                           inout logic [511:0] bz, inout int n,
                           input logic [7:0] d, input logic [1:0] p,
                           input logic s2, input int b);
    logic fb[$];
    fb.push_back(1'b0);
    for (int i = 0; i < DB; i++) fb.push_back(d[i]);
    if (p == 2'b01) fb.push_back(^d);
    else if (p == 2'b10) fb.push_back(~^d);
    fb.push_back(1'b1);
    if (s2) fb.push_back(1'b1);
    for (int k = 0; k < fb.size(); k++)
      for (int j = 0; j < b; j++)
        if (n < 512) begin
          w[n] = fb[k]; bz[n] = 1'b1; n++;
        end
    if (n > 0) dn[n-1] = 1'b1;
  endtask

  task automatic push_one(input logic [7:0] d);
    we_i = 1'b1; data_i = d;
    @(negedge clk_i);
    we_i = 1'b0;
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (tx_o === 1'b0) begin ok = 1'b1; return; end
      @(negedge clk_i);
    end
  endtask

  task automatic capture(input int n, output logic [511:0] tw,
                         output logic [511:0] dw, output logic [511:0] bw);
    tw = '1; dw = '0; bw = '0;
    for (int i = 0; i < n; i++) begin
      tw[i] = tx_o; dw[i] = done_o; bw[i] = busy_o;
      @(negedge clk_i);
    end
  endtask

  task automatic test_reset;
    bit ok;
    logic [511:0] tw, dw, bw;
    #1 rst_ni = 1'b0;
    #1;
    check_cnt++;
    if ({tx_o, busy_o, done_o, level_o, empty_o, full_o} !== {3'b100, 3'd0, 2'b10}) begin
      $display("FAIL reset_state: got tx/busy/done/level/empty/full=%b%b%b/%0d/%b%b want 100/0/10",
               tx_o, busy_o, done_o, level_o, empty_o, full_o);
    end else pass_cnt++;
    @(negedge clk_i); @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    // abort a frame of zeros with more queued behind it
    baud_div_i = 16'd3; parity_i = 2'b00; stop2_i = 1'b0;
    push_one(8'h00); push_one(8'h00); push_one(8'h00);
    wait_start(ok);
    check_cnt++;
    if (!ok) $display("FAIL reset_wait_start: got timeout want frame start");
    else pass_cnt++;
    repeat (9) @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    check_cnt++;
    if (tx_o !== 1'b1) $display("FAIL reset_async_tx: got %b want 1", tx_o);
    else pass_cnt++;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check_cnt++;
    if ({level_o, empty_o, busy_o} !== {3'd0, 1'b1, 1'b0})
      $display("FAIL reset_release: got level/empty/busy=%0d/%b/%b want 0/1/0", level_o, empty_o, busy_o);
    else pass_cnt++;
    capture(30, tw, dw, bw);
    check_cnt++;
    if (tw !== {512{1'b1}} || bw !== 512'd0)
      $display("FAIL reset_quiet: got tx=%h busy=%h want idle line", tw[63:0], bw[63:0]);
    else pass_cnt++;
  endtask

  task automatic test_single_8n1;
    logic [511:0] tw, dw, bw, ew, ed, eb;
    int n;
    baud_div_i = 16'd3; parity_i = 2'b00; stop2_i = 1'b0;
    we_i = 1'b1; data_i = 8'hA5;
    @(negedge clk_i);
    we_i = 1'b0;
    check_cnt++;
    if ({level_o, empty_o, tx_o} !== {3'd1, 1'b0, 1'b1})
      $display("FAIL push_visible: got level/empty/tx=%0d/%b/%b want 1/0/1", level_o, empty_o, tx_o);
    else pass_cnt++;
    @(negedge clk_i);
    check_cnt++;
    if ({tx_o, busy_o, level_o} !== {1'b0, 1'b1, 3'd0})
      $display("FAIL frame_start: got tx/busy/level=%b/%b/%0d want 0/1/0", tx_o, busy_o, level_o);
    else pass_cnt++;
    capture(44, tw, dw, bw);
    ew = '1; ed = '0; eb = '0; n = 0;
    add_frame(ew, ed, eb, n, 8'hA5, 2'b00, 1'b0, 4);
    check_cnt++;
    if (tw !== ew) $display("FAIL 8n1_line: got %h want %h", tw[63:0], ew[63:0]);
    else pass_cnt++;
    check_cnt++;
    if (dw !== ed || bw !== eb)
      $display("FAIL 8n1_done_busy: got done=%h busy=%h want done=%h busy=%h (len %0d)",
               dw[63:0], bw[63:0], ed[63:0], eb[63:0], n);
    else pass_cnt++;
  endtask

  task automatic test_parity;
    bit ok;
    logic [511:0] tw, dw, bw, ew, ed, eb;
    int n;
    logic [1:0] p;
    for (int it = 0; it < 2; it++) begin
      p = (it == 0) ? 2'b01 : 2'b10;
      baud_div_i = 16'd0; stop2_i = 1'b1; parity_i = p;
      push_one(8'h07);
      wait_start(ok);
      capture(16, tw, dw, bw);
      ew = '1; ed = '0; eb = '0; n = 0;
      add_frame(ew, ed, eb, n, 8'h07, p, 1'b1, 1);
      check_cnt++;
      if (!ok || tw !== ew || dw !== ed || bw !== eb)
        $display("FAIL parity_frame_%0d: got tx=%h done=%h want tx=%h done=%h",
                 p, tw[15:0], dw[15:0], ew[15:0], ed[15:0]);
      else pass_cnt++;
      check_cnt++;
      if (tw[9] !== ((p == 2'b01) ? 1'b1 : 1'b0))
        $display("FAIL parity_bit_%0d: got %b want %b", p, tw[9], (p == 2'b01));
      else pass_cnt++;
    end
  endtask

  task automatic test_full_drop;
    bit ok;
    logic [511:0] tw, dw, bw, ew, ed, eb;
    int n;
    logic [7:0] d;
    stall_i = 1'b1; baud_div_i = 16'd0; parity_i = 2'b00; stop2_i = 1'b0;
    mq.delete();
    for (int i = 0; i < 5; i++) begin
      d = 8'($urandom);
      push_one(d);
      if (mq.size() < DEP) mq.push_back(d);
    end
    check_cnt++;
    if ({full_o, level_o} !== {1'b1, 3'd4})
      $display("FAIL full_flags: got full/level=%b/%0d want 1/4", full_o, level_o);
    else pass_cnt++;
    stall_i = 1'b0;
    wait_start(ok);
    capture(50, tw, dw, bw);
    ew = '1; ed = '0; eb = '0; n = 0;
    while (mq.size() > 0) add_frame(ew, ed, eb, n, mq.pop_front(), 2'b00, 1'b0, 1);
    check_cnt++;
    if (!ok || tw !== ew || dw !== ed || bw !== eb)
      $display("FAIL full_drain: got tx=%h busy=%h want tx=%h busy=%h",
               tw[63:0], bw[63:0], ew[63:0], eb[63:0]);
    else pass_cnt++;
  endtask

  task automatic test_stall;
    bit ok;
    logic [511:0] tw, dw, bw, ew, ed, eb;
    int n;
    logic [7:0] d0, d1;
    baud_div_i = 16'd1; parity_i = 2'b00; stop2_i = 1'b0; stall_i = 1'b0;
    d0 = 8'($urandom); d1 = 8'($urandom);
    push_one(d0); push_one(d1);
    wait_start(ok);
    stall_i = 1'b1;
    capture(30, tw, dw, bw);
    ew = '1; ed = '0; eb = '0; n = 0;
    add_frame(ew, ed, eb, n, d0, 2'b00, 1'b0, 2);
    check_cnt++;
    if (!ok || tw !== ew || dw !== ed || bw !== eb)
      $display("FAIL stall_hold: got tx=%h busy=%h want tx=%h busy=%h",
               tw[63:0], bw[63:0], ew[63:0], eb[63:0]);
    else pass_cnt++;
    check_cnt++;
    if (level_o !== 3'd1) $display("FAIL stall_level: got %0d want 1", level_o);
    else pass_cnt++;
    stall_i = 1'b0;
    wait_start(ok);
    capture(24, tw, dw, bw);
    ew = '1; ed = '0; eb = '0; n = 0;
    add_frame(ew, ed, eb, n, d1, 2'b00, 1'b0, 2);
    check_cnt++;
    if (!ok || tw !== ew || dw !== ed)
      $display("FAIL stall_release: got tx=%h want %h", tw[63:0], ew[63:0]);
    else pass_cnt++;
  endtask

  task automatic test_config_latch;
    bit ok;
    logic [511:0] tw, dw, bw, ew, ed, eb;
    int n, cnt, b;
    logic [1:0] p0, p1;
    logic s0, s1;
    logic [7:0] d;
    for (int it = 0; it < 4; it++) begin
      b  = $urandom_range(1, 4);
      p0 = 2'($urandom); s0 = 1'($urandom);
      p1 = 2'($urandom); s1 = 1'($urandom);
      baud_div_i = 16'(b - 1); parity_i = p0; stop2_i = s0; stall_i = 1'b1;
      cnt = $urandom_range(2, 3);
      mq.delete();
      for (int i = 0; i < cnt; i++) begin
        d = 8'($urandom); push_one(d); mq.push_back(d);
      end
      stall_i = 1'b0;
      wait_start(ok);
      parity_i = p1; stop2_i = s1;
      ew = '1; ed = '0; eb = '0; n = 0;
      add_frame(ew, ed, eb, n, mq.pop_front(), p0, s0, b);
      while (mq.size() > 0) add_frame(ew, ed, eb, n, mq.pop_front(), p1, s1, b);
      capture(n + 6, tw, dw, bw);
      check_cnt++;
      if (!ok || tw !== ew || dw !== ed || bw !== eb)
        $display("FAIL config_latch_%0d: got tx=%h done=%h want tx=%h done=%h",
                 it, tw[127:0], dw[127:0], ew[127:0], ed[127:0]);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back;
    bit ok, pend;
    logic [511:0] tw, dw, bw, ew, ed, eb;
    int n, remaining, pushed_n, started_n, ncyc;
    logic [7:0] d, all_q[$];
    stall_i = 1'b1; baud_div_i = 16'd0; parity_i = 2'b00; stop2_i = 1'b0;
    all_q.delete();
    for (int i = 0; i < 2; i++) begin
      d = 8'($urandom); push_one(d); all_q.push_back(d);
    end
    pushed_n = 2; started_n = 1; remaining = 2 * DEP; pend = 1'b0;
    stall_i = 1'b0;
    wait_start(ok);
    check_cnt++;
    if (!ok) $display("FAIL b2b_start: got timeout want frame start");
    else pass_cnt++;
    ncyc = (2 + 2 * DEP) * 10 + 5;
    tw = '1; dw = '0; bw = '0;
    for (int i = 0; i < ncyc; i++) begin
      tw[i] = tx_o; dw[i] = done_o; bw[i] = busy_o;
      if (pend) begin
        check_cnt++;
        if (level_o !== LW'(pushed_n - started_n))
          $display("FAIL pushpop_level: got %0d want %0d", level_o, pushed_n - started_n);
        else pass_cnt++;
        pend = 1'b0;
      end
      if (done_o === 1'b1 && remaining > 0) begin
        d = 8'($urandom);
        we_i = 1'b1; data_i = d;
        all_q.push_back(d);
        pushed_n++; started_n++; remaining--; pend = 1'b1;
      end else we_i = 1'b0;
      @(negedge clk_i);
    end
    we_i = 1'b0;
    ew = '1; ed = '0; eb = '0; n = 0;
    foreach (all_q[k]) add_frame(ew, ed, eb, n, all_q[k], 2'b00, 1'b0, 1);
    check_cnt++;
    if (tw !== ew || dw !== ed || bw !== eb)
      $display("FAIL b2b_stream: got tx=%h busy=%h want tx=%h busy=%h",
               tw[127:0], bw[127:0], ew[127:0], eb[127:0]);
    else pass_cnt++;
    check_cnt++;
    if ({level_o, empty_o, busy_o} !== {3'd0, 1'b1, 1'b0})
      $display("FAIL b2b_final: got level/empty/busy=%0d/%b/%b want 0/1/0", level_o, empty_o, busy_o);
    else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_single_8n1;
    test_parity;
    test_full_drop;
    test_stall;
    test_config_latch;
    test_back_to_back;
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
